mem_wb_stage: RTL and testbench

// - EX/MEM register, data-memory access and MEM/WB register of the 5-stage pipeline.
// - Source of every forwarding operand the EX stage consumes:
//   - ALUResult_mem, RegWriteAddr_mem, RegWrite_mem;
//   - RegWriteData_wb, RegWriteAddr_wb, RegWrite_wb.
// - Drives a req/ack data-memory port and stalls the pipeline while an access is outstanding.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/dmem_handshake.sv | 53 +++++
 rtl/mem_wb_stage.sv | 116 +++++++++++
 tb/tb_mem_wb_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Types and defaults shared by the pipeline stages: MEM-stage handshake state,
// datapath/address widths and the ack-timeout counter width.
package cpu_pkg;

  localparam int DW_DEF          = 32;
  localparam int AW_DEF          = 32;
  localparam int CNT_W           = 4;
  localparam int ACK_TIMEOUT_DEF = 15;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Control bits carried by the EX/MEM register alongside the data words.
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ack sequencer: tracks an outstanding access, stalls the
// pipeline until ack, and forces completion after ACK_TIMEOUT wait cycles.
module dmem_handshake
  import cpu_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic access,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic stall,
  output logic timeout_err
);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              timeout_err_q, timeout_err_d;
  logic              timed_out;

  assign timed_out = (state_q == WAIT) && (count_q == CNT_W'(ACK_TIMEOUT));

  always_comb begin
    state_d       = state_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      IDLE: if (access && !dmem_ack) state_d = WAIT;
      WAIT: if (dmem_ack || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Counts WAIT cycles only; the first WAIT cycle sees zero.
    count_d = ((state_q == WAIT) && (state_d == WAIT)) ? count_q + CNT_W'(1) : '0;
    if (timed_out && !dmem_ack) timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign dmem_req    = access;
  assign stall       = access && !dmem_ack && !timed_out;
  assign timeout_err = timeout_err_q;

endmodule

// File: rtl/mem_wb_stage.sv
// EX/MEM register, data-memory access and MEM/WB register. Load data reaches
// the rest of the pipeline only through the registered _wb outputs.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int AW          = AW_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] ALUResult_ex,
  input  logic [DW-1:0] MemWriteData_ex,
  input  logic [4:0]    RegWriteAddr_ex,
  input  logic          RegWrite_ex,
  input  logic          MemRead_ex,
  input  logic          MemWrite_ex,
  input  logic          MemtoReg_ex,
  output logic [DW-1:0] ALUResult_mem,
  output logic [4:0]    RegWriteAddr_mem,
  output logic          RegWrite_mem,
  output logic [DW-1:0] RegWriteData_wb,
  output logic [4:0]    RegWriteAddr_wb,
  output logic          RegWrite_wb,
  output logic          Stall_mem,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          timeout_err
);

  ex_mem_ctrl_t  ctrl_q, ctrl_d;
  logic [DW-1:0] alu_result_q, alu_result_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [4:0]    wb_addr_q, wb_addr_d;
  logic          wb_write_q, wb_write_d;
  logic          mem_access;
  logic [DW-1:0] load_data;

  assign mem_access = ctrl_q.mem_read | ctrl_q.mem_write;

  dmem_handshake #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_handshake (
    .clk        (clk),
    .rst_n      (rst_n),
    .access     (mem_access),
    .dmem_ack   (dmem_ack),
    .dmem_req   (dmem_req),
    .stall      (Stall_mem),
    .timeout_err(timeout_err)
  );

  // A forced (timed-out) completion has no ack, so it writes back zero.
  assign load_data = dmem_ack ? dmem_rdata : '0;

  always_comb begin
    ctrl_d       = ctrl_q;
    alu_result_d = alu_result_q;
    mem_wdata_d  = mem_wdata_q;
    if (!Stall_mem) begin
      ctrl_d.rd         = RegWriteAddr_ex;
      ctrl_d.reg_write  = RegWrite_ex;
      ctrl_d.mem_read   = MemRead_ex;
      ctrl_d.mem_write  = MemWrite_ex;
      ctrl_d.mem_to_reg = MemtoReg_ex;
      alu_result_d      = ALUResult_ex;
      mem_wdata_d       = MemWriteData_ex;
    end
  end

  // Stalled cycles push an all-zero bubble so the older instr writes back once.
  always_comb begin
    wb_data_d  = '0;
    wb_addr_d  = '0;
    wb_write_d = 1'b0;
    if (!Stall_mem) begin
      wb_data_d  = ctrl_q.mem_to_reg ? load_data : alu_result_q;
      wb_addr_d  = ctrl_q.rd;
      wb_write_d = ctrl_q.reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      alu_result_q <= '0;
      mem_wdata_q  <= '0;
      wb_data_q    <= '0;
      wb_addr_q    <= '0;
      wb_write_q   <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      alu_result_q <= alu_result_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_data_q    <= wb_data_d;
      wb_addr_q    <= wb_addr_d;
      wb_write_q   <= wb_write_d;
    end
  end

  assign ALUResult_mem    = alu_result_q;
  assign RegWriteAddr_mem = ctrl_q.rd;
  assign RegWrite_mem     = ctrl_q.reg_write;
  assign RegWriteData_wb  = wb_data_q;
  assign RegWriteAddr_wb  = wb_addr_q;
  assign RegWrite_wb      = wb_write_q;
  assign dmem_we          = ctrl_q.mem_write;
  assign dmem_addr        = alu_result_q[AW-1:0];
  assign dmem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU pass-through, waited/zero-wait/timed-out
// accesses, mid-access reset and an ALU-then-load sequence on the same register.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALUResult_ex, MemWriteData_ex;
  logic [4:0]  RegWriteAddr_ex;
  logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex;
  logic [31:0] ALUResult_mem;
  logic [4:0]  RegWriteAddr_mem;
  logic        RegWrite_mem;
  logic [31:0] RegWriteData_wb;
  logic [4:0]  RegWriteAddr_wb;
  logic        RegWrite_wb;
  logic        Stall_mem, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack, timeout_err;

  int n_total = 0;
  int n_pass  = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .RegWriteAddr_ex(RegWriteAddr_ex), .RegWrite_ex(RegWrite_ex),
    .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex),
    .ALUResult_mem(ALUResult_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
    .RegWrite_mem(RegWrite_mem), .RegWriteData_wb(RegWriteData_wb),
    .RegWriteAddr_wb(RegWriteAddr_wb), .RegWrite_wb(RegWrite_wb),
    .Stall_mem(Stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-18s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
    ALUResult_ex    = alu;
    MemWriteData_ex = wd;
    RegWriteAddr_ex = rd;
    RegWrite_ex     = rw;
    MemRead_ex      = mr;
    MemWrite_ex     = mw;
    MemtoReg_ex     = m2r;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_rdata = 32'h0;
    dmem_ack   = 1'b0;
    tick();
    tick();
    chk("rst_alu_mem", ALUResult_mem, 32'h0);
    chk("rst_wb_write", {31'b0, RegWrite_wb}, 32'h0);
    chk("rst_stall", {31'b0, Stall_mem}, 32'h0);
    chk("rst_req", {31'b0, dmem_req}, 32'h0);
    chk("rst_timeout", {31'b0, timeout_err}, 32'h0);
    rst_n = 1'b1;

    // ALU instruction
    drive_ex(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("alu_mem_result", ALUResult_mem, 32'h1234);
    chk("alu_mem_addr", {27'b0, RegWriteAddr_mem}, 32'd5);
    chk("alu_mem_write", {31'b0, RegWrite_mem}, 32'd1);
    drive_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("alu_wb_data", RegWriteData_wb, 32'h1234);
    chk("alu_wb_addr", {27'b0, RegWriteAddr_wb}, 32'd5);
    chk("alu_wb_write", {31'b0, RegWrite_wb}, 32'd1);

    // Load, ack three cycles after req
    drive_ex(32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive_ex(32'h999, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("ld_req", {31'b0, dmem_req}, 32'd1);
    chk("ld_we", {31'b0, dmem_we}, 32'd0);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_stall_c0", {31'b0, Stall_mem}, 32'd1);
    tick();
    chk("ld_stall_c1", {31'b0, Stall_mem}, 32'd1);
    chk("ld_held", ALUResult_mem, 32'h100);
    chk("ld_bubble_c1", {31'b0, RegWrite_wb}, 32'd0);
    tick();
    chk("ld_stall_c2", {31'b0, Stall_mem}, 32'd1);
    chk("ld_bubble_c2", {31'b0, RegWrite_wb}, 32'd0);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    settle();
    chk("ld_stall_c3", {31'b0, Stall_mem}, 32'd0);
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    chk("ld_wb_data", RegWriteData_wb, 32'hCAFEF00D);
    chk("ld_wb_addr", {27'b0, RegWriteAddr_wb}, 32'd9);
    chk("ld_wb_write", {31'b0, RegWrite_wb}, 32'd1);
    chk("ld_next_ex", ALUResult_mem, 32'h999);

    // Store, zero-wait ack
    drive_ex(32'h40, 32'hDEAD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_ack = 1'b1;
    settle();
    chk("st_req", {31'b0, dmem_req}, 32'd1);
    chk("st_we", {31'b0, dmem_we}, 32'd1);
    chk("st_addr", dmem_addr, 32'h40);
    chk("st_wdata", dmem_wdata, 32'hDEAD);
    chk("st_stall", {31'b0, Stall_mem}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    chk("st_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("st_wb_write", {31'b0, RegWrite_wb}, 32'd0);

    // Ack never arrives: bounded count of stall cycles
    drive_ex(32'h200, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_rdata = 32'h55555555;
    settle();
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!Stall_mem) break;
      stall_cnt++;
      tick();
    end
    chk("to_stall_cycles", stall_cnt, 32'd16);
    chk("to_err_before", {31'b0, timeout_err}, 32'd0);
    tick();
    chk("to_err", {31'b0, timeout_err}, 32'd1);
    chk("to_wb_data", RegWriteData_wb, 32'h0);
    chk("to_wb_write", {31'b0, RegWrite_wb}, 32'd1);
    chk("to_wb_addr", {27'b0, RegWriteAddr_wb}, 32'd3);
    tick();
    chk("to_err_sticky", {31'b0, timeout_err}, 32'd1);
    dmem_rdata = 32'h0;

    // Reset while waiting on ack
    drive_ex(32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rw_stall_pre", {31'b0, Stall_mem}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rw_req", {31'b0, dmem_req}, 32'd0);
    chk("rw_stall", {31'b0, Stall_mem}, 32'd0);
    chk("rw_alu_mem", ALUResult_mem, 32'h0);
    chk("rw_wb_write", {31'b0, RegWrite_wb}, 32'd0);
    chk("rw_timeout", {31'b0, timeout_err}, 32'd0);
    rst_n = 1'b1;

    // ALU writes r7, then load r7
    drive_ex(32'h77, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive_ex(32'h500, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    settle();
    chk("b2b_fwd_result", ALUResult_mem, 32'h77);
    chk("b2b_fwd_addr", {27'b0, RegWriteAddr_mem}, 32'd7);
    tick();
    drive_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("b2b_stall", {31'b0, Stall_mem}, 32'd1);
    chk("b2b_wb_data", RegWriteData_wb, 32'h77);
    chk("b2b_wb_write", {31'b0, RegWrite_wb}, 32'd1);
    tick();
    chk("b2b_bubble", {31'b0, RegWrite_wb}, 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h12345678;
    settle();
    chk("b2b_ack_stall", {31'b0, Stall_mem}, 32'd0);
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    chk("b2b_ld_data", RegWriteData_wb, 32'h12345678);
    chk("b2b_ld_write", {31'b0, RegWrite_wb}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
